adc_capture_writer: RTL
=======================

// Module: adc_capture_writer
// PURPOSE
// - Sits between the sinc3 decimators (vco_adc x3) and the two 32x512 capture SRAMs.
// - Selects one decimator channel and writes each valid sample into SRAM.
// - Ping-pong over bank 0 / bank 1; flags full banks for the Wishbone reader.
// - Stalls and drops samples (with a sticky overrun flag) when no bank is free.
// PARAMETERS
// - ADDR_W  9   SRAM word address width (512 words per bank)
// - DATA_W  32  decimator sample width / SRAM word width
// - N_CH    3   number of decimator channels
// PORTS
// - clk            in   1       capture clock, same net as SRAM clk0
// - rst_n          in   1       asynchronous active-low reset
// - start_i        in   1       pulse: arm capture; ch_sel_i and last_word_i sampled here
// - stop_i         in   1       pulse: end capture after any in-flight write
// - ch_sel_i       in   2       channel select (0..N_CH-1); values >= N_CH select ch 0
// - last_word_i    in   ADDR_W  last address written per bank (bank depth - 1)
// - adc_dvalid_i   in   N_CH    per-channel one-cycle sample strobe
// - adc0_dat_i     in   DATA_W  ch0 sample (adc1_dat_i, adc2_dat_i identical)
// - bank_release_i in   2       pulse per bank: reader has consumed that bank
// - mem_wenb_o     out  2       active-low write enable per bank (drives csb0/web0)
// - mem_waddr_o    out  ADDR_W  write address
// - mem_data_o     out  DATA_W  write data
// - wmask_o        out  4       byte write mask
// - bank_full_o    out  2       bank holds unread data
// - last_addr_o    out  ADDR_W  last address written in most recently filled bank
// - overrun_o      out  1       sticky: a sample was dropped; cleared by start_i
// - busy_o         out  1       high in any state except IDLE
// - irq_o          out  1       one-cycle pulse on any bank_full_o rising edge
// BEHAVIOUR
// - Reset: mem_wenb_o=2'b11, wmask_o=4'hF; every other output 0; state IDLE, bank 0, addr 0.
// - States: IDLE, CAPTURE, WAIT_BANK.
// - IDLE -> CAPTURE on start_i.
//   - Clears overrun_o; target = lowest-numbered non-full bank, addr 0.
//   - If both banks are full, goes to WAIT_BANK instead.
// - Accept: in CAPTURE, adc_dvalid_i[ch_sel] high; strobes on other channels ignored.
// - Write latency: accepted sample appears registered the next cycle.
//   - mem_wenb_o[target] low for exactly 1 cycle, with mem_waddr_o and mem_data_o.
// - After a write at addr == last_word_i:
//   - set bank_full_o[target]; last_addr_o = last_word_i; pulse irq_o.
//   - toggle target, addr 0.
//   - New target already full -> WAIT_BANK.
// - Otherwise addr increments by 1; no wrap past last_word_i.
// - WAIT_BANK:
//   - Accepted strobes are not written; overrun_o is set.
//   - bank_release_i[target] -> CAPTURE at addr 0; a strobe in that same cycle is dropped.
// - bank_release_i[b] clears bank_full_o[b] in any state.
//   - Same-cycle set and release of one bank: set wins.
// - stop_i (CAPTURE/WAIT_BANK) -> IDLE after any pending write completes.
//   - If addr > 0: set bank_full_o[target], last_addr_o = addr-1, pulse irq_o.
//   - Strobe coincident with stop_i is written.
// - start_i while busy_o: ignored. stop_i in IDLE: ignored.
// - start_i and stop_i in the same cycle: stop wins.
// - rst_n assertion mid-write: the write is abandoned; wenb goes 2'b11 immediately.
// CONFIGURATION
// - PACK16_EN defined:
//   - Each sample is saturated to unsigned 16 bits (0xFFFF if dat[31:16] != 0).
//   - First sample goes to [15:0], second to [31:16]; one write per sample pair, wmask_o=4'hF.
//   - stop_i with an odd sample pending writes it with wmask_o=4'b0011.
// - PACK16_EN undefined: one 32-bit word per sample, wmask_o tied to 4'hF; no pack register.
// TESTING
// - Reset: rst_n=0 -> mem_wenb_o=2'b11, bank_full_o=0, busy_o=0, irq_o=0, wmask_o=4'hF.
// - Fill bank 0: start_i, ch_sel=1, last_word=3; ch1 samples 0x10..0x13 -> bank0 writes addr0..3.
//   - Result: bank_full_o=01, one irq_o pulse; 5th sample goes to bank1 addr0.
// - Channel filter: adc_dvalid_i=3'b001 with ch_sel=1 -> no write, addr unchanged.
// - Overrun: both banks full, 2 more strobes -> no wenb, overrun_o=1.
//   - Then release bank0 -> next strobe written to bank0 addr0.
// - Partial stop: 2 samples then stop_i -> IDLE, bank_full_o[0]=1, last_addr_o=1.
//   - Reset mid-capture: outputs return to reset values.
// - PACK16_EN: samples 0x1234, 0x00020000 -> one write 0xFFFF1234, wmask 4'hF.
//   - 3rd sample then stop_i -> write 0x0000xxxx with wmask 4'b0011.

Source files
------------

// File: rtl/adc_capture_writer.sv
// adc_capture_writer: selects one decimator channel and writes its samples into
// ping-pong capture SRAM banks. Optional 16-bit sample packing under PACK16_EN.
module adc_capture_writer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int N_CH   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [1:0]        ch_sel_i,
    input  logic [ADDR_W-1:0] last_word_i,
    input  logic [N_CH-1:0]   adc_dvalid_i,
    input  logic [DATA_W-1:0] adc0_dat_i,
    input  logic [DATA_W-1:0] adc1_dat_i,
    input  logic [DATA_W-1:0] adc2_dat_i,
    input  logic [1:0]        bank_release_i,
    output logic [1:0]        mem_wenb_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [3:0]        wmask_o,
    output logic [1:0]        bank_full_o,
    output logic [ADDR_W-1:0] last_addr_o,
    output logic              overrun_o,
    output logic              busy_o,
    output logic              irq_o
);
    typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_BANK} state_t;

    state_t            state;
    logic [1:0]        ch_sel;
    logic [ADDR_W-1:0] last_word;
    logic [ADDR_W-1:0] addr;
    logic              target;

    logic              sel_valid;
    logic [DATA_W-1:0] sample;
    logic              strobe;
    logic              stopping;
    logic              do_write;
    logic              wrap;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_mask;
    logic [ADDR_W-1:0] addr_after;
    logic [1:0]        tgt_bit;
    logic [1:0]        set_mask;
    logic [1:0]        full_next;

`ifdef PACK16_EN
    logic [15:0] pack_lo;
    logic [15:0] pack_lo_n;
    logic        pack_half;
    logic        pack_half_n;
    logic [15:0] sat;
`endif

    always_comb begin
        sel_valid = adc_dvalid_i[0];
        sample    = adc0_dat_i;
        case (ch_sel)
            2'd1: begin sel_valid = adc_dvalid_i[1]; sample = adc1_dat_i; end
            2'd2: begin sel_valid = adc_dvalid_i[2]; sample = adc2_dat_i; end
            default: ;
        endcase
    end

    always_comb begin
        strobe   = (state == CAPTURE) && sel_valid;
        stopping = stop_i && (state != IDLE);
        tgt_bit  = target ? 2'b10 : 2'b01;
        wr_mask  = 4'hF;
`ifdef PACK16_EN
        sat         = (|sample[DATA_W-1:16]) ? 16'hFFFF : sample[15:0];
        pack_lo_n   = pack_lo;
        pack_half_n = pack_half;
        do_write    = 1'b0;
        wr_data     = '0;
        if (strobe && pack_half) begin
            do_write       = 1'b1;
            wr_data[31:16] = sat;
            wr_data[15:0]  = pack_lo;
            pack_half_n    = 1'b0;
        end else if (strobe) begin
            pack_lo_n   = sat;
            pack_half_n = 1'b1;
            // A first half arriving with stop is flushed immediately as an odd word.
            if (stopping) begin
                do_write      = 1'b1;
                wr_data[15:0] = sat;
                wr_mask       = 4'b0011;
                pack_half_n   = 1'b0;
            end
        end else if (stopping && pack_half) begin
            do_write      = 1'b1;
            wr_data[15:0] = pack_lo;
            wr_mask       = 4'b0011;
            pack_half_n   = 1'b0;
        end
`else
        do_write = strobe;
        wr_data  = sample;
`endif
        wrap = do_write && (addr == last_word);
        if (wrap)
            addr_after = '0;
        else if (do_write)
            addr_after = addr + 1'b1;
        else
            addr_after = addr;
        set_mask = '0;
        if (wrap || (stopping && addr_after != '0))
            set_mask = tgt_bit;
        // Set is ORed after release so a same-cycle set of one bank wins.
        full_next = (bank_full_o & ~bank_release_i) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch_sel      <= '0;
            last_word   <= '0;
            addr        <= '0;
            target      <= 1'b0;
            mem_wenb_o  <= '1;
            mem_waddr_o <= '0;
            mem_data_o  <= '0;
            wmask_o     <= '1;
            bank_full_o <= '0;
            last_addr_o <= '0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
            irq_o       <= 1'b0;
`ifdef PACK16_EN
            pack_lo     <= '0;
            pack_half   <= 1'b0;
`endif
        end else begin
            mem_wenb_o <= 2'b11;
            wmask_o    <= 4'hF;
            if (do_write) begin
                mem_wenb_o  <= ~tgt_bit;
                mem_waddr_o <= addr;
                mem_data_o  <= wr_data;
                wmask_o     <= wr_mask;
            end
            bank_full_o <= full_next;
            irq_o       <= |(full_next & ~bank_full_o);
            if (wrap)
                last_addr_o <= last_word;
            else if (|set_mask)
                last_addr_o <= addr_after - 1'b1;
`ifdef PACK16_EN
            pack_lo   <= pack_lo_n;
            pack_half <= pack_half_n;
`endif
            case (state)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        overrun_o <= 1'b0;
                        addr      <= '0;
                        last_word <= last_word_i;
                        ch_sel    <= (32'(ch_sel_i) >= N_CH) ? 2'd0 : ch_sel_i;
                        busy_o    <= 1'b1;
                        if (!full_next[0]) begin
                            target <= 1'b0;
                            state  <= CAPTURE;
                        end else if (!full_next[1]) begin
                            target <= 1'b1;
                            state  <= CAPTURE;
                        end else begin
                            target <= 1'b0;
                            state  <= WAIT_BANK;
                        end
                    end
                end
                CAPTURE: begin
                    addr <= addr_after;
                    if (wrap)
                        target <= ~target;
                    if (stopping) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        addr   <= '0;
                    end else if (wrap && full_next[~target]) begin
                        state <= WAIT_BANK;
                    end
                end
                WAIT_BANK: begin
                    if (sel_valid)
                        overrun_o <= 1'b1;
                    if (stopping) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (bank_release_i[target]) begin
                        state <= CAPTURE;
                        addr  <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
